mem_bus_responder: RTL



---
 rtl/mem_bus_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_responder
// Description : Memory-side responder for the cs/we/oe/addr/data CPU bus with
//               programmable wait states and a one-cycle ready pulse.
//               Optional write protection via `define MEM_WRITE_PROTECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
`ifdef MEM_WRITE_PROTECT_EN
    ,
    parameter logic [ADDR_WIDTH-1:0] PROT_LIMIT = ADDR_WIDTH'('h1C)
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
`ifdef MEM_WRITE_PROTECT_EN
    input  logic                  wp_lock,
    output logic                  wr_err,
`endif
    output logic                  ready,
    output logic                  busy
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam bit         HAS_WAIT  = (WAIT_STATES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ready_q;
    logic                    busy_q;
`ifdef MEM_WRITE_PROTECT_EN
    logic                    wr_err_q;
`endif

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    w_wr_block;
    logic                    w_mem_we;
    logic                    w_drive;

`ifdef MEM_WRITE_PROTECT_EN
    // wp_lock is looked at live, so the lock state at the ACCESS edge decides.
    assign w_wr_block = we_q && wp_lock && (addr_q < PROT_LIMIT);
    assign wr_err     = wr_err_q;
`else
    assign w_wr_block = 1'b0;
`endif

    // State is forced to IDLE asynchronously, so a pending write cannot land once reset hits.
    assign w_mem_we = rst_n && (state_q == S_ACCESS) && we_q && !w_wr_block;
    assign w_drive  = (state_q == S_DONE) && !we_q && oe;

    assign data  = w_drive ? rdata_q : {DATA_WIDTH{1'bz}};
    assign ready = ready_q;
    assign busy  = busy_q;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
            wr_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        wdata_q <= data;
                        busy_q  <= 1'b1;
                        if (HAS_WAIT) begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= mem_q[addr_q];
                    end
                    ready_q <= 1'b1;
`ifdef MEM_WRITE_PROTECT_EN
                    wr_err_q <= w_wr_block;
`endif
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
                    wr_err_q <= 1'b0;
`endif
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
